issue_scheduler: RTL and testbench

Issue controller placed in front of the 19-bit instruction input of the 3-stage core (register read, ALU/Buffer1, Buffer2/writeback).
It buffers instructions from an upstream valid/ready source in a small FIFO and drives one instruction per clock into the core.
It inserts NOP bubbles on read-after-write hazards, because the core has no forwarding.
It also provides run/drain control and issue/stall statistics.

---
 rtl/issue_scheduler.sv | 103 ++++++++++
 tb/tb_issue_scheduler.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/issue_scheduler.sv
// issue_scheduler: FIFO-buffered issue stage that inserts NOP bubbles on RAW hazards
// for a 3-stage core without forwarding, with run/drain control and statistics.
module issue_scheduler #(
    parameter int          FIFO_DEPTH    = 4,
    parameter int          HAZARD_WINDOW = 3,
    parameter logic [15:0] WR_MASK       = 16'h00FF,
    parameter logic [3:0]  NOP_OPCODE    = 4'hF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          run,
    input  logic                          in_valid,
    input  logic [18:0]                   in_instr,
    output logic                          in_ready,
    output logic [18:0]                   instruccion,
    output logic                          issue_valid,
    output logic                          busy,
    output logic                          drain_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [15:0]                   issue_cnt,
    output logic [15:0]                   stall_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int SB = HAZARD_WINDOW - 1;
    localparam logic [18:0] NOP  = {NOP_OPCODE, 15'b0};
    localparam logic [AW:0] FULL = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t      state_q, state_d;
    logic [18:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] wp_q, rp_q;
    logic [AW:0] cnt_q;
    logic [18:0] instr_q;
    logic        valid_q, done_q;
    logic [15:0] icnt_q, scnt_q;
    // each entry is {writes_rf, WA} of a recently issued slot, newest at index 0
    logic [5:0]  sb_q [SB];
    logic [18:0] head;
    logic        empty, push, pop, stall, blocked, wr_any;

    assign head  = mem_q[rp_q];
    assign empty = cnt_q == '0;
    assign push  = in_valid && in_ready;
    assign pop   = state_q == RUN && run && !empty && !blocked;
    assign stall = state_q == RUN && !empty && blocked;

    always_comb begin
        blocked = 1'b0;
        wr_any  = 1'b0;
        for (int i = 0; i < SB; i++) begin
            wr_any  = wr_any | sb_q[i][5];
            blocked = blocked | (sb_q[i][5] &&
                      (sb_q[i][4:0] == head[9:5] || sb_q[i][4:0] == head[4:0]));
        end
    end

    always_comb begin
        state_d = state_q == IDLE ? (run ? RUN : IDLE) :
                  state_q == RUN  ? (run ? RUN : DRAIN) :
                  run ? RUN : (wr_any ? DRAIN : IDLE);
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wp_q] <= in_instr;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            wp_q    <= '0;
            rp_q    <= '0;
            cnt_q   <= '0;
            instr_q <= NOP;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            icnt_q  <= '0;
            scnt_q  <= '0;
            for (int i = 0; i < SB; i++) sb_q[i] <= '0;
        end else begin
            state_q <= state_d;
            wp_q    <= wp_q + AW'(push);
            rp_q    <= rp_q + AW'(pop);
            cnt_q   <= cnt_q + (AW + 1)'(push) - (AW + 1)'(pop);
            instr_q <= pop ? head : NOP;
            valid_q <= pop;
            done_q  <= state_q == DRAIN && state_d == IDLE;
            icnt_q  <= icnt_q + 16'(pop && icnt_q != 16'hFFFF);
            scnt_q  <= scnt_q + 16'(stall && scnt_q != 16'hFFFF);
            sb_q[0] <= pop ? {WR_MASK[head[18:15]], head[14:10]} : 6'b0;
            for (int i = 1; i < SB; i++) sb_q[i] <= sb_q[i-1];
        end
    end

    assign in_ready    = cnt_q != FULL;
    assign instruccion = instr_q;
    assign issue_valid = valid_q;
    assign busy        = state_q != IDLE;
    assign drain_done  = done_q;
    assign fifo_count  = cnt_q;
    assign issue_cnt   = icnt_q;
    assign stall_cnt   = scnt_q;
endmodule

// File: tb/tb_issue_scheduler.sv
// tb_issue_scheduler: scoreboard bench; accepted instructions are queued and
// matched in order against issued slots, bubbles must carry the NOP encoding.
module tb_issue_scheduler;
    logic        clk = 1'b0;
    logic        rst, run, in_valid;
    logic [18:0] in_instr;
    logic        in_ready, issue_valid, busy, drain_done;
    logic [18:0] instruccion;
    logic [2:0]  fifo_count;
    logic [15:0] issue_cnt, stall_cnt;

    issue_scheduler dut (
        .clk(clk), .rst(rst), .run(run), .in_valid(in_valid), .in_instr(in_instr),
        .in_ready(in_ready), .instruccion(instruccion), .issue_valid(issue_valid),
        .busy(busy), .drain_done(drain_done), .fifo_count(fifo_count),
        .issue_cnt(issue_cnt), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int          n_tests = 0, n_fail = 0;
    int          cyc = 0, prev_cyc = -1, last_gap = 0, max_gap = 0, dd_count = 0;
    logic [18:0] exp_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [18:0] mk(input int op, input int wa, input int r1, input int r2);
        return {op[3:0], wa[4:0], r1[4:0], r2[4:0]};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (drain_done) dd_count++;
            if (issue_valid) begin
                chk("exp_q_nonempty", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) chk("issue", 32'(instruccion), 32'(exp_q.pop_front()));
                if (prev_cyc >= 0) begin
                    last_gap = cyc - prev_cyc;
                    if (last_gap > max_gap) max_gap = last_gap;
                end
                prev_cyc = cyc;
            end else begin
                chk("bubble", 32'(instruccion), 32'h78000);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        run = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        prev_cyc = -1;
        last_gap = 0;
        max_gap = 0;
        dd_count = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic push(input logic [18:0] v);
        int n = 0;
        in_valid = 1'b1;
        in_instr = v;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("push_timeout", 32'(n < 100), 1);
        exp_q.push_back(v);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_empty();
        int n = 0;
        while ((exp_q.size() != 0 || fifo_count != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", 32'(n < 200), 1);
        repeat (4) @(negedge clk);
    endtask

    task automatic start_run();
        run = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        run = 1'b0;
        in_valid = 1'b0;
        in_instr = '0;
        do_reset();

        // reset mid-stream with three queued instructions
        push(mk(0, 1, 2, 3));
        push(mk(1, 4, 5, 6));
        push(mk(2, 7, 8, 9));
        chk("pre_rst_count", 32'(fifo_count), 3);
        do_reset();
        chk("rst_instr", 32'(instruccion), 32'h78000);
        chk("rst_valid", 32'(issue_valid), 0);
        chk("rst_count", 32'(fifo_count), 0);
        chk("rst_icnt", 32'(issue_cnt), 0);
        chk("rst_scnt", 32'(stall_cnt), 0);
        chk("rst_ready", 32'(in_ready), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(drain_done), 0);

        // independent stream issues back to back
        start_run();
        push(mk(0, 1, 2, 3));
        push(mk(1, 4, 5, 6));
        push(mk(2, 7, 8, 9));
        wait_empty();
        chk("indep_gap", 32'(max_gap), 1);
        chk("indep_icnt", 32'(issue_cnt), 3);
        chk("indep_scnt", 32'(stall_cnt), 0);

        // RAW via RA1
        do_reset();
        start_run();
        push(mk(0, 5, 1, 2));
        push(mk(1, 6, 5, 7));
        wait_empty();
        chk("raw1_gap", 32'(last_gap), 3);
        chk("raw1_scnt", 32'(stall_cnt), 2);
        chk("raw1_icnt", 32'(issue_cnt), 2);

        // RAW via RA2
        do_reset();
        start_run();
        push(mk(0, 5, 1, 2));
        push(mk(1, 6, 7, 5));
        wait_empty();
        chk("raw2_gap", 32'(last_gap), 3);
        chk("raw2_scnt", 32'(stall_cnt), 2);

        // non-writer opcode creates no hazard
        do_reset();
        start_run();
        push(mk(8, 5, 1, 2));
        push(mk(1, 6, 5, 7));
        wait_empty();
        chk("nowr_gap", 32'(last_gap), 1);
        chk("nowr_scnt", 32'(stall_cnt), 0);

        // full FIFO backpressure and recovery
        do_reset();
        for (int i = 1; i <= 4; i++) push(mk(i, 20 + i, 1, 2));
        chk("full_count", 32'(fifo_count), 4);
        chk("full_ready", 32'(in_ready), 0);
        chk("full_busy", 32'(busy), 0);
        in_valid = 1'b1;
        in_instr = mk(5, 25, 1, 2);
        repeat (2) @(negedge clk);
        chk("held_count", 32'(fifo_count), 4);
        chk("held_ready", 32'(in_ready), 0);
        run = 1'b1;
        @(negedge clk);
        chk("run_ready0", 32'(in_ready), 0);
        chk("run_count0", 32'(fifo_count), 4);
        @(negedge clk);
        chk("pop_ready", 32'(in_ready), 1);
        chk("pop_count", 32'(fifo_count), 3);
        exp_q.push_back(in_instr);
        @(negedge clk);
        in_valid = 1'b0;
        wait_empty();
        chk("full_icnt", 32'(issue_cnt), 5);

        // drain completes three cycles after the writer's issue cycle
        do_reset();
        start_run();
        push(mk(3, 9, 1, 2));
        @(negedge clk);
        chk("dr_t_valid", 32'(issue_valid), 1);
        chk("dr_t_instr", 32'(instruccion), 32'(mk(3, 9, 1, 2)));
        run = 1'b0;
        @(negedge clk);
        chk("dr_t1_valid", 32'(issue_valid), 0);
        chk("dr_t1_busy", 32'(busy), 1);
        chk("dr_t1_done", 32'(drain_done), 0);
        @(negedge clk);
        chk("dr_t2_busy", 32'(busy), 1);
        chk("dr_t2_done", 32'(drain_done), 0);
        @(negedge clk);
        chk("dr_t3_done", 32'(drain_done), 1);
        chk("dr_t3_busy", 32'(busy), 0);
        @(negedge clk);
        chk("dr_t4_done", 32'(drain_done), 0);

        // drain aborted by run returning at t+2
        do_reset();
        start_run();
        push(mk(3, 9, 1, 2));
        @(negedge clk);
        run = 1'b0;
        repeat (2) @(negedge clk);
        chk("ab_t2_busy", 32'(busy), 1);
        run = 1'b1;
        @(negedge clk);
        chk("ab_t3_done", 32'(drain_done), 0);
        chk("ab_t3_busy", 32'(busy), 1);
        push(mk(4, 10, 11, 12));
        wait_empty();
        chk("ab_dd_count", 32'(dd_count), 0);
        chk("ab_icnt", 32'(issue_cnt), 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: time %0t exceeded limit 200000", $time);
        $fatal(1);
    end
endmodule
